i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx : stereo I2S transmitter with a double-buffered sample path.
//
// Frame timing is fixed: 2048 clk per stereo frame, 32 clk per serial bit,
// 32 bit slots per channel half. A 16-bit sample is sent MSB first in
// slots 1..16, which gives the standard one-bit I2S delay after each word
// select edge. All other slots carry zero.
//
// Ports
//   clk        in   system clock, rising edge active
//   rst_n      in   asynchronous active-low reset
//   wrt        in   one-clk strobe, loads lft_in/rght_in into the holding buffer
//   lft_in     in   [15:0] left sample, two's complement
//   rght_in    in   [15:0] right sample, two's complement
//   I2S_sclk   out  serial bit clock, clk/32, 50% duty
//   I2S_ws     out  word select, 0 = left, 1 = right, clk/2048
//   I2S_data   out  serial data, registered, changes on the sclk falling edge
//   smpl_req   out  one-clk pulse at every frame start
//   underrun   out  one-clk pulse when a frame starts with an empty buffer
//   overrun    out  one-clk pulse when a full buffer is overwritten
// ---------------------------------------------------------------------------
module i2s_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] lft_in,
  input  logic [15:0] rght_in,
  output logic        I2S_sclk,
  output logic        I2S_ws,
  output logic        I2S_data,
  output logic        smpl_req,
  output logic        underrun,
  output logic        overrun
);

  // Bit carried by a given slot: slot k in 1..16 carries sample[16-k].
  function automatic logic slot_bit(input logic [15:0] smp, input logic [4:0] slot);
    logic [4:0] idx;
    idx = 5'd16 - slot;
    if ((slot != 5'd0) && (slot <= 5'd16)) begin
      slot_bit = smp[idx[3:0]];
    end else begin
      slot_bit = 1'b0;
    end
  endfunction

  logic [10:0] cnt_r;
  logic [15:0] hold_lft_r;
  logic [15:0] hold_rght_r;
  logic        full_r;
  logic [15:0] shadow_lft_r;
  logic [15:0] shadow_rght_r;
  logic        data_r;
  logic        smpl_req_r;
  logic        underrun_r;
  logic        overrun_r;

  logic [10:0] cnt_nxt_s;
  logic        frame_end_s;
  logic        bit_end_s;
  logic        data_nxt_s;
  logic        full_nxt_s;
  logic        ovr_nxt_s;
  logic        und_nxt_s;

  // Decode counter boundaries and compute next-state values.
  always_comb begin
    cnt_nxt_s   = cnt_r + 11'd1;
    frame_end_s = (cnt_r == 11'd2047);
    bit_end_s   = (cnt_r[4:0] == 5'd31);
    data_nxt_s  = 1'b0;
    full_nxt_s  = full_r;
    ovr_nxt_s   = 1'b0;
    und_nxt_s   = 1'b0;

    // Data for the slot being entered; channel chosen by the next ws value.
    if (cnt_nxt_s[10]) begin
      data_nxt_s = slot_bit(shadow_rght_r, cnt_nxt_s[9:5]);
    end else begin
      data_nxt_s = slot_bit(shadow_lft_r, cnt_nxt_s[9:5]);
    end

    // A strobe always leaves the buffer full, even on the transfer edge,
    // because the transfer consumes the pre-edge contents.
    if (wrt) begin
      full_nxt_s = 1'b1;
    end else if (frame_end_s) begin
      full_nxt_s = 1'b0;
    end else begin
      full_nxt_s = full_r;
    end

    // Overwrite only counts as overrun when nothing is drained that cycle.
    if (wrt && full_r && !frame_end_s) begin
      ovr_nxt_s = 1'b1;
    end else begin
      ovr_nxt_s = 1'b0;
    end

    if (frame_end_s && !full_r) begin
      und_nxt_s = 1'b1;
    end else begin
      und_nxt_s = 1'b0;
    end
  end

  // Free-running frame counter; sclk and ws are taken straight from its bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 11'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Holding buffer written by the sample source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_lft_r  <= 16'h0000;
      hold_rght_r <= 16'h0000;
      full_r      <= 1'b0;
    end else begin
      if (wrt) begin
        hold_lft_r  <= lft_in;
        hold_rght_r <= rght_in;
      end
      full_r <= full_nxt_s;
    end
  end

  // Shadow buffer feeding the serializer; an empty buffer repeats the last sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_lft_r  <= 16'h0000;
      shadow_rght_r <= 16'h0000;
    end else if (frame_end_s && full_r) begin
      shadow_lft_r  <= hold_lft_r;
      shadow_rght_r <= hold_rght_r;
    end
  end

  // Serial data register, updated only on the sclk falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= 1'b0;
    end else if (bit_end_s) begin
      data_r <= data_nxt_s;
    end
  end

  // Registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpl_req_r <= 1'b0;
      underrun_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      smpl_req_r <= frame_end_s;
      underrun_r <= und_nxt_s;
      overrun_r  <= ovr_nxt_s;
    end
  end

  assign I2S_sclk = cnt_r[4];
  assign I2S_ws   = cnt_r[10];
  assign I2S_data = data_r;
  assign smpl_req = smpl_req_r;
  assign underrun = underrun_r;
  assign overrun  = overrun_r;

endmodule
